// File: rtl/rect_wave_gen_pkg.sv
// Shared types and defaults for the rectangular/trapezoidal wave generator.
package rect_wave_gen_pkg;

  localparam int DEF_W_AMP = 12;
  localparam int DEF_W_T   = 16;

  // Encodings reported on the phase output
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_DELAY = 3'd1;
  localparam logic [2:0] PH_RISE  = 3'd2;
  localparam logic [2:0] PH_HIGH  = 3'd3;
  localparam logic [2:0] PH_FALL  = 3'd4;
  localparam logic [2:0] PH_LOW   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = PH_IDLE,
    ST_DELAY = PH_DELAY,
    ST_RISE  = PH_RISE,
    ST_HIGH  = PH_HIGH,
    ST_FALL  = PH_FALL,
    ST_LOW   = PH_LOW
  } state_t;

endpackage

// File: rtl/rect_wave_gen_if.sv
// Configuration and output bundle of rect_wave_gen.
// With RECT_WAVE_GEN_BURST_EN defined, burst_n and done are added.
interface rect_wave_gen_if
  import rect_wave_gen_pkg::*;
#(
  parameter int W_AMP = DEF_W_AMP,
  parameter int W_T   = DEF_W_T
);

  logic             en;
  logic [W_AMP-1:0] amp;
  logic [W_T-1:0]   td;
  logic [W_T-1:0]   tr;
  logic [W_T-1:0]   th;
  logic [W_T-1:0]   tf;
  logic [W_T-1:0]   tl;
  logic [W_AMP-1:0] rise_step;
  logic [W_AMP-1:0] fall_step;
  logic [W_AMP-1:0] code;
  logic [2:0]       phase;
  logic             period_strb;
`ifdef RECT_WAVE_GEN_BURST_EN
  logic [W_T-1:0]   burst_n;
  logic             done;
`endif

  modport master (
    output en, amp, td, tr, th, tf, tl, rise_step, fall_step,
`ifdef RECT_WAVE_GEN_BURST_EN
    output burst_n,
    input  done,
`endif
    input  code, phase, period_strb
  );

  modport slave (
    input  en, amp, td, tr, th, tf, tl, rise_step, fall_step,
`ifdef RECT_WAVE_GEN_BURST_EN
    input  burst_n,
    output done,
`endif
    output code, phase, period_strb
  );

endinterface

// File: rtl/rwg_phase_timer.sv
// Loadable down-counter timing each generator phase. Loading duration d
// leaves d-1 in the counter, so zero marks the last cycle of the phase.
// A zero-duration load behaves like a one-cycle load and is flagged on skip.
module rwg_phase_timer #(
  parameter int W_T = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W_T-1:0] load_val,
  output logic           zero,
  output logic           skip
);

  localparam logic [W_T-1:0] T_ZERO = {W_T{1'b0}};
  localparam logic [W_T-1:0] T_ONE  = {{(W_T-1){1'b0}}, 1'b1};

  logic [W_T-1:0] count_r;

  // Reload on phase entry, otherwise count down and rest at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= T_ZERO;
    end else if (load) begin
      count_r <= (load_val == T_ZERO) ? T_ZERO : (load_val - T_ONE);
    end else if (count_r != T_ZERO) begin
      count_r <= count_r - T_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == T_ZERO);
  assign skip = load && (load_val == T_ZERO);

endmodule

// File: rtl/rect_wave_gen.sv
// Rectangular / trapezoidal amplitude generator:
// IDLE -> DELAY -> (RISE -> HIGH -> FALL -> LOW) repeating.
// Optional macro RECT_WAVE_GEN_BURST_EN: stop after burst_n periods, flag done.
module rect_wave_gen
  import rect_wave_gen_pkg::*;
#(
  parameter int W_AMP = DEF_W_AMP,
  parameter int W_T   = DEF_W_T
) (
  input logic            clk,
  input logic            rst,
  rect_wave_gen_if.slave bus
);

  localparam logic [W_T-1:0]   T_ZERO = {W_T{1'b0}};
  localparam logic [W_AMP-1:0] A_ZERO = {W_AMP{1'b0}};

  state_t           state_r, state_n_s;
  logic [W_AMP-1:0] code_r, code_n_s;
  logic             strb_r, strb_n_s;
  // Rise duration is consumed by the timer load at period start, so only
  // the parameters needed later in the period get a shadow copy.
  logic [W_AMP-1:0] sh_amp_r, sh_rstep_r, sh_fstep_r;
  logic [W_T-1:0]   sh_th_r, sh_tf_r, sh_tl_r;
  logic             ld_s;
  logic [W_T-1:0]   ld_dur_s;
  logic             tmr_zero_s, tmr_skip_unused_s;
  logic             start_s, period_end_s, stop_s;
  logic             last_period_s, idle_hold_s;
  logic [W_AMP-1:0] amp_e_s, rstep_e_s, fstep_e_s;
  logic [W_AMP:0]   sum_s, diff_s;

  rwg_phase_timer #(.W_T(W_T)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_s),
    .load_val (ld_dur_s),
    .zero     (tmr_zero_s),
    .skip     (tmr_skip_unused_s)
  );

  // Next state and timer reload; zero-length phases are chained past in one cycle
  always_comb begin
    state_n_s    = state_r;
    ld_s         = 1'b0;
    ld_dur_s     = T_ZERO;
    start_s      = 1'b0;
    period_end_s = 1'b0;
    stop_s       = 1'b0;
    if (!bus.en) begin
      state_n_s = ST_IDLE;
      ld_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (idle_hold_s) begin
            state_n_s = ST_IDLE;
          end else if (bus.td != T_ZERO) begin
            state_n_s = ST_DELAY;
            ld_s      = 1'b1;
            ld_dur_s  = bus.td;
          end else begin
            start_s = 1'b1;
          end
        end
        ST_DELAY: begin
          if (tmr_zero_s) start_s = 1'b1;
          else            state_n_s = ST_DELAY;
        end
        ST_RISE: begin
          if (!tmr_zero_s)            begin state_n_s = ST_RISE; end
          else if (sh_th_r != T_ZERO) begin state_n_s = ST_HIGH; ld_s = 1'b1; ld_dur_s = sh_th_r; end
          else if (sh_tf_r != T_ZERO) begin state_n_s = ST_FALL; ld_s = 1'b1; ld_dur_s = sh_tf_r; end
          else if (sh_tl_r != T_ZERO) begin state_n_s = ST_LOW;  ld_s = 1'b1; ld_dur_s = sh_tl_r; end
          else                        begin start_s = 1'b1; period_end_s = 1'b1; end
        end
        ST_HIGH: begin
          if (!tmr_zero_s)            begin state_n_s = ST_HIGH; end
          else if (sh_tf_r != T_ZERO) begin state_n_s = ST_FALL; ld_s = 1'b1; ld_dur_s = sh_tf_r; end
          else if (sh_tl_r != T_ZERO) begin state_n_s = ST_LOW;  ld_s = 1'b1; ld_dur_s = sh_tl_r; end
          else                        begin start_s = 1'b1; period_end_s = 1'b1; end
        end
        ST_FALL: begin
          if (!tmr_zero_s)            begin state_n_s = ST_FALL; end
          else if (sh_tl_r != T_ZERO) begin state_n_s = ST_LOW;  ld_s = 1'b1; ld_dur_s = sh_tl_r; end
          else                        begin start_s = 1'b1; period_end_s = 1'b1; end
        end
        ST_LOW: begin
          if (!tmr_zero_s) state_n_s = ST_LOW;
          else begin start_s = 1'b1; period_end_s = 1'b1; end
        end
        default: begin
          state_n_s = ST_IDLE;
          ld_s      = 1'b1;
        end
      endcase
      // A new period picks its first non-empty phase from the live inputs;
      // with every duration zero it falls back to a single LOW cycle.
      if (start_s) begin
        ld_s = 1'b1;
        if (period_end_s && last_period_s) begin
          stop_s    = 1'b1;
          state_n_s = ST_IDLE;
        end else if (bus.tr != T_ZERO) begin
          state_n_s = ST_RISE; ld_dur_s = bus.tr;
        end else if (bus.th != T_ZERO) begin
          state_n_s = ST_HIGH; ld_dur_s = bus.th;
        end else if (bus.tf != T_ZERO) begin
          state_n_s = ST_FALL; ld_dur_s = bus.tf;
        end else begin
          state_n_s = ST_LOW;  ld_dur_s = bus.tl;
        end
      end else begin
        stop_s = 1'b0;
      end
    end
  end

  assign strb_n_s  = start_s && !stop_s;
  // On a period start the incoming parameters apply immediately
  assign amp_e_s   = strb_n_s ? bus.amp       : sh_amp_r;
  assign rstep_e_s = strb_n_s ? bus.rise_step : sh_rstep_r;
  assign fstep_e_s = strb_n_s ? bus.fall_step : sh_fstep_r;

  // Amplitude for the cycle being entered, computed one bit wide then clamped
  always_comb begin
    sum_s    = {1'b0, code_r} + {1'b0, rstep_e_s};
    diff_s   = {1'b0, code_r} - {1'b0, fstep_e_s};
    code_n_s = A_ZERO;
    case (state_n_s)
      ST_RISE: begin
        if (sum_s > {1'b0, amp_e_s}) code_n_s = amp_e_s;
        else                         code_n_s = sum_s[W_AMP-1:0];
      end
      ST_HIGH: code_n_s = amp_e_s;
      ST_FALL: begin
        if (diff_s[W_AMP]) code_n_s = A_ZERO;
        else               code_n_s = diff_s[W_AMP-1:0];
      end
      default: code_n_s = A_ZERO;
    endcase
  end

  // Registered state, amplitude word, strobe and per-period shadow copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      code_r     <= A_ZERO;
      strb_r     <= 1'b0;
      sh_amp_r   <= A_ZERO;
      sh_rstep_r <= A_ZERO;
      sh_fstep_r <= A_ZERO;
      sh_th_r    <= T_ZERO;
      sh_tf_r    <= T_ZERO;
      sh_tl_r    <= T_ZERO;
    end else begin
      state_r <= state_n_s;
      code_r  <= code_n_s;
      strb_r  <= strb_n_s;
      if (strb_n_s) begin
        sh_amp_r   <= bus.amp;
        sh_rstep_r <= bus.rise_step;
        sh_fstep_r <= bus.fall_step;
        sh_th_r    <= bus.th;
        sh_tf_r    <= bus.tf;
        sh_tl_r    <= bus.tl;
      end
    end
  end

`ifdef RECT_WAVE_GEN_BURST_EN
  logic [W_T-1:0] burst_cnt_r;
  logic           done_r;

  assign last_period_s = (bus.burst_n != T_ZERO) &&
                         (({1'b0, burst_cnt_r} + {T_ZERO, 1'b1}) == {1'b0, bus.burst_n});
  assign idle_hold_s   = done_r;
  assign bus.done      = done_r;

  // Completed-period count and sticky done flag, both cleared when en drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_r <= T_ZERO;
      done_r      <= 1'b0;
    end else if (!bus.en) begin
      burst_cnt_r <= T_ZERO;
      done_r      <= 1'b0;
    end else if (stop_s) begin
      burst_cnt_r <= T_ZERO;
      done_r      <= 1'b1;
    end else if (period_end_s) begin
      burst_cnt_r <= burst_cnt_r + {{(W_T-1){1'b0}}, 1'b1};
    end
  end
`else
  assign last_period_s = 1'b0;
  assign idle_hold_s   = 1'b0;
`endif

  assign bus.code        = code_r;
  assign bus.phase       = state_r;
  assign bus.period_strb = strb_r;

endmodule

// File: doc/rect_wave_gen.md
RECT_WAVE_GEN -- requirements
Module: rect_wave_gen

Interface
REQ-001 SHALL have parameter W_AMP, default 12, amplitude code width.
REQ-002 SHALL have parameter W_T, default 16, phase-duration width in clock cycles.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1, run request; low forces IDLE.
REQ-006 SHALL have port amp, input, W_AMP, pulse level (Irect I equivalent).
REQ-007 SHALL have ports td, tr, th, tf, tl, input, W_T each: initial delay, rise, high, fall and low durations in cycles.
REQ-008 SHALL have ports rise_step and fall_step, input, W_AMP each: per-cycle code increment and decrement during ramps.
REQ-009 SHALL have port code, output, W_AMP, registered amplitude word to the downstream DAC-driven Irect/Idc source.
REQ-010 SHALL have port phase, output, 3, current state encoding.
REQ-011 SHALL have port period_strb, output, 1, one-cycle pulse on each entry to RISE.

Function
REQ-012 SHALL implement states IDLE, DELAY, RISE, HIGH, FALL and LOW.
REQ-013 SHALL go IDLE->DELAY on the first cycle en=1, latching td into the phase timer.
REQ-014 SHALL latch amp, tr, th, tf, tl, rise_step and fall_step into shadow registers on every entry to RISE; input changes mid-period SHALL take effect at the next period only.
REQ-015 SHALL keep each state for exactly its latched duration, then advance DELAY->RISE->HIGH->FALL->LOW->RISE.
REQ-016 SHALL skip a zero-duration state in the same cycle, with no cycle spent in it.
REQ-017 SHALL, when tr+th+tf+tl=0, spend 1 cycle in LOW per period so the period is never zero.
REQ-018 SHALL, in RISE, add rise_step to code each cycle, saturating at amp.
REQ-019 SHALL force code=amp on the cycle HIGH is entered.
REQ-020 SHALL, in FALL, subtract fall_step from code each cycle, saturating at 0.
REQ-021 SHALL force code=0 on the cycle LOW is entered; code SHALL be 0 in IDLE and DELAY.
REQ-022 SHALL, on en=0 in any state, enter IDLE on the next edge with code=0 and period_strb=0.
REQ-023 SHALL have no arithmetic wrap: all code arithmetic is done at W_AMP+1 bits and then clamped.

Reset
REQ-024 SHALL, on rst, asynchronously set state=IDLE, code=0, phase=IDLE, period_strb=0, timer=0 and shadow registers=0.
REQ-025 SHALL, when rst is released while en=1, start at DELAY on the first clock edge after release.

Configuration
REQ-026 SHALL, with RECT_WAVE_GEN_BURST_EN defined, add input burst_n (W_T) and output done (1): stop after burst_n full periods by completing LOW, entering IDLE and holding done=1 until en falls; burst_n=0 SHALL mean unlimited.
REQ-027 SHALL, without RECT_WAVE_GEN_BURST_EN, run continuously, with no burst_n or done ports.

Structure
REQ-028 SHALL place the state enum, the phase encodings and the default W_AMP/W_T in package rect_wave_gen_pkg.
REQ-029 SHALL implement the phase timer as sub-module rwg_phase_timer: a loadable down-counter with a zero flag and a skip-on-load-zero output.

Verification
REQ-030 SHALL cover: amp=100, td=2, tr=4, th=3, tf=4, tl=3, steps=25 -> code 0,0,25,50,75,100,100,100,100,75,50,25,0,0,0,0 repeating; period_strb every 14 cycles.
REQ-031 SHALL cover: tr=0, tf=0, th=5, tl=5, amp=7 -> square wave 7/0, 5 cycles each, with no ramp cycles.
REQ-032 SHALL cover: all four durations 0 -> code stays 0 and period_strb asserts every cycle.
REQ-033 SHALL cover: rise_step=60, amp=100, tr=3 -> code 60,100,100, then HIGH.
REQ-034 SHALL cover: amp changed 50->80 mid-HIGH -> current period holds 50 and the next period peaks at 80.
REQ-035 SHALL cover: rst asserted mid-FALL -> code=0 and phase=IDLE immediately without a clock edge; with BURST_EN and burst_n=2, done=1 after the second LOW.
